// File: rtl/toy_loader_pkg.sv
// Shared defaults for the toy_loader load register and its history.
package toy_loader_pkg;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_CNT_W      = 8;
   localparam int DEF_HIST_DEPTH = 4;

   typedef logic [DEF_WIDTH-1:0] word_t;

endpackage : toy_loader_pkg

// File: rtl/toy_loader_hist.sv
// Shift-register history of previously held words.
// Entry 0 is the most recent prior value; the oldest entry falls off the end.
module toy_loader_hist #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_shift,
   input  logic [WIDTH-1:0]       i_din,
   output logic [WIDTH*DEPTH-1:0] o_hist
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Push the incoming word at the head and age every entry by one slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_shift) begin
         r_mem[0] <= i_din;
         for (int i = 1; i < DEPTH; i++) begin
            r_mem[i] <= r_mem[i-1];
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_pack
      assign o_hist[g*WIDTH +: WIDTH] = r_mem[g];
   end

endmodule : toy_loader_hist

// File: rtl/toy_loader.sv
// Load register with bookkeeping: valid flag, load pulse, change detect,
// saturating load counter and a short history of earlier values.
// All outputs come straight from flops; inputs are used as-is on clk.
module toy_loader
   import toy_loader_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int HIST_DEPTH = DEF_HIST_DEPTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [WIDTH-1:0]            data,
   input  logic                        load_enable,
   output logic [WIDTH-1:0]            q,
   output logic                        q_valid,
   output logic                        load_pulse,
   output logic                        changed,
   output logic [CNT_W-1:0]            load_count,
   output logic [WIDTH*HIST_DEPTH-1:0] hist
);

   logic [WIDTH-1:0] r_q;
   logic             r_q_valid;
   logic             r_load_pulse;
   logic             r_changed;
   logic [CNT_W-1:0] r_count;

   logic             w_cnt_full;
   logic             w_differs;

   assign w_cnt_full = (r_count == {CNT_W{1'b1}});
   // The first load after reset always counts as a change, even if data is 0.
   assign w_differs  = (data != r_q) || !r_q_valid;

   // Capture data and update the per-load status flags and counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q          <= '0;
         r_q_valid    <= 1'b0;
         r_load_pulse <= 1'b0;
         r_changed    <= 1'b0;
         r_count      <= '0;
      end else begin
         r_load_pulse <= load_enable;
         r_changed    <= load_enable && w_differs;
         if (load_enable) begin
            r_q       <= data;
            r_q_valid <= 1'b1;
            if (!w_cnt_full) begin
               r_count <= r_count + CNT_W'(1);
            end
         end
      end
   end

   // History sees the value being replaced, so it shifts on the same edge.
   toy_loader_hist #(
      .WIDTH (WIDTH),
      .DEPTH (HIST_DEPTH)
   ) u_hist (
      .clk     (clk),
      .reset   (reset),
      .i_shift (load_enable),
      .i_din   (r_q),
      .o_hist  (hist)
   );

   assign q          = r_q;
   assign q_valid    = r_q_valid;
   assign load_pulse = r_load_pulse;
   assign changed    = r_changed;
   assign load_count = r_count;

endmodule : toy_loader

// File: tb/tb_toy_loader.sv
// Bench for toy_loader: two instances (default counter and 3-bit counter)
// share stimulus and are checked against a queue-based reference model.
module tb_toy_loader;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int C1 = 8;
   localparam int C2 = 3;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [W-1:0]   data = '0;
   logic           load_enable = 1'b0;

   logic [W-1:0]   q1, q2;
   logic           qv1, qv2, lp1, lp2, ch1, ch2;
   logic [C1-1:0]  cnt1;
   logic [C2-1:0]  cnt2;
   logic [W*D-1:0] h1, h2;

   toy_loader #(.WIDTH(W), .CNT_W(C1), .HIST_DEPTH(D)) dut1 (
      .clk(clk), .reset(reset), .data(data), .load_enable(load_enable),
      .q(q1), .q_valid(qv1), .load_pulse(lp1), .changed(ch1),
      .load_count(cnt1), .hist(h1)
   );

   toy_loader #(.WIDTH(W), .CNT_W(C2), .HIST_DEPTH(D)) dut2 (
      .clk(clk), .reset(reset), .data(data), .load_enable(load_enable),
      .q(q2), .q_valid(qv2), .load_pulse(lp2), .changed(ch2),
      .load_count(cnt2), .hist(h2)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit cmp_on = 1'b0;

   // Reference model: value, flags, total number of loads, history queue.
   logic [W-1:0] m_q = '0;
   bit           m_valid = 1'b0;
   bit           m_pulse = 1'b0;
   bit           m_changed = 1'b0;
   int           m_loads = 0;
   logic [W-1:0] mh[$] = '{8'h00, 8'h00, 8'h00, 8'h00};

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q = '0; m_valid = 0; m_pulse = 0; m_changed = 0; m_loads = 0;
         mh = '{8'h00, 8'h00, 8'h00, 8'h00};
      end else if (load_enable) begin
         m_pulse   = 1;
         m_changed = (data != m_q) || !m_valid;
         mh.push_front(m_q);
         void'(mh.pop_back());
         m_q     = data;
         m_valid = 1;
         m_loads++;
      end else begin
         m_pulse   = 0;
         m_changed = 0;
      end
   end

   function automatic logic [W*D-1:0] model_hist();
      logic [W*D-1:0] v;
      v = '0;
      for (int i = 0; i < D; i++) v[i*W +: W] = mh[i];
      return v;
   endfunction

   function automatic int sat(input int n, input int cw);
      int mx;
      mx = (1 << cw) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("q1", 64'(q1), 64'(m_q));
         chk("q_valid1", 64'(qv1), 64'(m_valid));
         chk("load_pulse1", 64'(lp1), 64'(m_pulse));
         chk("changed1", 64'(ch1), 64'(m_changed));
         chk("load_count1", 64'(cnt1), 64'(sat(m_loads, C1)));
         chk("hist1", 64'(h1), 64'(model_hist()));
         chk("q2", 64'(q2), 64'(m_q));
         chk("changed2", 64'(ch2), 64'(m_changed));
         chk("load_count2", 64'(cnt2), 64'(sat(m_loads, C2)));
         chk("hist2", 64'(h2), 64'(model_hist()));
      end
   end

   // Drive inputs at negedge, then land just after the next rising edge.
   task automatic step(input logic le, input logic [W-1:0] d);
      @(negedge clk);
      load_enable = le;
      data        = d;
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle reset pulse; outputs must clear before any clock edge.
   task automatic rst_pulse(input int ns);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_q", 64'(q1), 64'h0);
      chk("rst_q_valid", 64'(qv1), 64'h0);
      chk("rst_count", 64'(cnt1), 64'h0);
      chk("rst_hist", 64'(h1), 64'h0);
      chk("rst_pulse", 64'(lp1), 64'h0);
      chk("rst_changed", 64'(ch1), 64'h0);
      chk("rst_count2", 64'(cnt2), 64'h0);
      #(ns - 1);
      reset = 1'b0;
   endtask

   initial begin
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      cmp_on = 1'b1;

      // Build up some state, then reset with a load pending.
      step(1, 8'h55);
      step(1, 8'h66);
      data = 8'hA5; load_enable = 1'b1;
      rst_pulse(10);

      // Single load from a clean reset.
      step(0, 8'h00);
      rst_pulse(4);
      step(1, 8'h3A);
      chk("single_q", 64'(q1), 64'h3A);
      chk("single_valid", 64'(qv1), 64'h1);
      chk("single_pulse", 64'(lp1), 64'h1);
      chk("single_changed", 64'(ch1), 64'h1);
      chk("single_count", 64'(cnt1), 64'h1);
      chk("single_hist0", 64'(h1[7:0]), 64'h00);
      step(0, 8'h77);
      chk("idle_pulse", 64'(lp1), 64'h0);
      chk("idle_changed", 64'(ch1), 64'h0);
      chk("idle_q", 64'(q1), 64'h3A);

      // Tracking across consecutive enabled edges.
      rst_pulse(4);
      step(1, 8'h3A);
      chk("trk_q0", 64'(q1), 64'h3A);
      chk("trk_ch0", 64'(ch1), 64'h1);
      step(1, 8'h3A);
      chk("trk_q1", 64'(q1), 64'h3A);
      chk("trk_ch1", 64'(ch1), 64'h0);
      step(1, 8'hFF);
      chk("trk_q2", 64'(q1), 64'hFF);
      chk("trk_ch2", 64'(ch1), 64'h1);
      chk("trk_count", 64'(cnt1), 64'h3);
      chk("trk_hist0", 64'(h1[7:0]), 64'h3A);

      // Reset while loading; the first edge after release loads normally.
      data = 8'h3A; load_enable = 1'b1;
      rst_pulse(15);
      @(posedge clk); #1;
      chk("rel_q", 64'(q1), 64'h3A);
      chk("rel_changed", 64'(ch1), 64'h1);
      chk("rel_count", 64'(cnt1), 64'h1);

      // Hold with data toggling.
      for (int i = 0; i < 5; i++) step(0, (i % 2) ? 8'hFF : 8'h00);
      chk("hold_q", 64'(q1), 64'h3A);
      chk("hold_count", 64'(cnt1), 64'h1);
      chk("hold_hist", 64'(h1), 64'h0);

      // Saturation of both counters.
      load_enable = 1'b0;
      rst_pulse(4);
      for (int i = 0; i < 10; i++) step(1, 8'($urandom));
      chk("sat3_count", 64'(cnt2), 64'h7);
      chk("sat3_count1", 64'(cnt1), 64'd10);
      for (int i = 0; i < 250; i++) step(1, 8'($urandom));
      chk("sat8_count", 64'(cnt1), 64'hFF);
      step(1, 8'h12);
      chk("sat8_hold", 64'(cnt1), 64'hFF);
      chk("sat3_hold", 64'(cnt2), 64'h7);

      // Randomized traffic with occasional resets; model checks each cycle.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            load_enable = 1'($urandom_range(0, 1));
            rst_pulse(4);
         end
         step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3) * 8'h41));
      end

      @(negedge clk);
      cmp_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_toy_loader

// File: doc/toy_loader.md
Name: toy_loader

Overview:
- Clocked load register with bookkeeping. Captures an input data word on every rising clock edge where load_enable is high, and holds it otherwise.
- Reports whether the register has been loaded since reset, how many loads have occurred, whether the last load changed the value, and a short history of loaded values.
- Standalone leaf block for simple configuration/test-data capture; no upstream handshake beyond the load strobe.

Parameters:
- WIDTH, 8, data/register width in bits.
- CNT_W, 8, width of saturating load counter.
- HIST_DEPTH, 4, number of previously loaded values retained (>=1).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately, released synchronously by the user.
- data  input  WIDTH  word to capture.
- load_enable  input  1  level-sensitive load strobe, sampled on rising clk.
- q  output  WIDTH  currently held word.
- q_valid  output  1  high once at least one load has occurred since reset.
- load_pulse  output  1  high for exactly the cycle after each load edge (registered).
- changed  output  1  registered; high for the cycle after a load whose data differed from the previous q (or first load after reset).
- load_count  output  CNT_W  number of loads since reset, saturating at all-ones.
- hist  output  WIDTH*HIST_DEPTH  previous q values; slice [WIDTH-1:0] is the most recent prior value.

Behaviour:
- Reset (asynchronous, active-high, dominant): q=0, q_valid=0, load_pulse=0, changed=0, load_count=0, hist=all zeros. Reset overrides load_enable on any edge while asserted.
- Load: on rising clk with reset=0 and load_enable=1: q<=data; one-cycle latency, so q shows the new value after that edge. Simultaneously hist shifts: hist[0]<=old q, hist[i]<=hist[i-1]; the oldest entry is dropped.
- load_enable held high for N edges gives N loads. q tracks data each cycle, and data may change while enabled.
- load_enable=0: q, hist, q_valid and load_count hold; load_pulse=0, changed=0.
- q_valid: set on the first load and stays set until reset.
- changed: on a load edge, changed<=(data!=q) OR (q_valid==0). It is cleared on any non-load edge.
- load_count: increments by 1 per load. At all-ones it stays at all-ones (no wrap).
- Reset mid-operation (load_enable still high): all state clears immediately, regardless of clock. The first rising edge after reset deasserts with load_enable=1 performs a normal load.
- Inputs are not registered or synchronised inside the block. data and load_enable must meet setup/hold to clk.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package: toy_loader_pkg with default width constants (WIDTH, CNT_W, HIST_DEPTH) and a typedef for the data word.
- One natural sub-module: toy_loader_hist, a parameterised shift-register history with async reset and shift enable. Everything else lives in the top module.

Test Plan:
- Reset: assert reset mid-cycle for 10 ns with data=0xA5, load_enable=1 -> q=0, q_valid=0, load_count=0, hist=0 immediately, without waiting for a clock edge.
- Single load: data=0x3A, load_enable=1 for one edge -> next cycle q=0x3A, q_valid=1, load_pulse=1, changed=1, load_count=1, hist[0]=0x00. The following cycle with enable low: load_pulse=0, changed=0, q holds 0x3A.
- Tracking load: load_enable high across 3 edges with data 0x3A, 0x3A, 0xFF -> q=0x3A, 0x3A, 0xFF. changed=1, 0, 1. load_count increments by 3. hist[0]=0x3A after the last load.
- Reset during enabled load: load_enable=1, data=0x3A, reset pulsed for 15 ns -> all outputs 0 during reset. The first edge after release loads 0x3A with changed=1 and load_count=1.
- Hold: load_enable=0 while data toggles 0x00/0xFF for 5 cycles -> q, hist, load_count unchanged.
- Saturation: with CNT_W=3, perform 10 consecutive loads -> load_count reaches 7 and stays at 7.
